// File: rtl/spi_helpers_multi_sync_filter_pkg.sv
// Shared constants for the multi-channel SPI input synchronizer/filter.
package spi_helpers_multi_sync_filter_pkg;

    // Fewer than two flops does not give metastability time to resolve.
    localparam int SPI_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_helpers_multi_sync_filter_if.sv
// Pad-side inputs, filter controls and filtered/edge outputs of the SPI input filter.
interface spi_helpers_multi_sync_filter_if #(
    parameter int N_CH   = 4,
    parameter int FILT_W = 3
);
    logic [N_CH-1:0]   in_;
    logic [N_CH-1:0]   filt_en;
    logic [FILT_W-1:0] filt_len;
    logic              glitch_clr;
    logic [N_CH-1:0]   out;
    logic [N_CH-1:0]   posedge_;
    logic [N_CH-1:0]   negedge_;
    logic              any_edge;
    logic [N_CH-1:0]   glitch;

    modport master (
        output in_, filt_en, filt_len, glitch_clr,
        input  out, posedge_, negedge_, any_edge, glitch
    );

    modport slave (
        input  in_, filt_en, filt_len, glitch_clr,
        output out, posedge_, negedge_, any_edge, glitch
    );
endinterface

// File: rtl/spi_helpers_multi_sync_filter_ch.sv
// One channel: synchronizer chain, optional deglitch filter, edge detect, sticky glitch flag.
module spi_helpers_multi_sync_filter_ch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_W      = 3,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_i,
    input  logic              filt_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              glitch_clr_i,
    output logic              out_o,
    output logic              posedge_o,
    output logic              negedge_o,
    output logic              glitch_o
);
    typedef logic [FILT_W-1:0] cnt_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic                   prev_q, prev_d;
    cnt_t                   cnt_q, cnt_d;
    logic                   glitch_q, glitch_d;
    logic                   raw;

    always_comb begin
        raw      = sync_q[SYNC_STAGES-1];
        sync_d   = {sync_q[SYNC_STAGES-2:0], in_i};
        prev_d   = filt_q;
        filt_d   = filt_q;
        cnt_d    = '0;
        glitch_d = glitch_q;
        if (!filt_en_i) begin
            filt_d = raw;
        end else if (raw != filt_q) begin
            // >= rather than == so a lowered filt_len takes effect at once
            if (cnt_q >= filt_len_i) filt_d = raw;
            else                     cnt_d  = cnt_q + 1'b1;
        end
        // An abort in the same cycle as a clear wins, so no event is lost.
        if (filt_en_i && (cnt_q != '0) && (raw == filt_q)) glitch_d = 1'b1;
        else if (glitch_clr_i)                             glitch_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            filt_q   <= RESET_VAL;
            prev_q   <= RESET_VAL;
            cnt_q    <= '0;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            filt_q   <= filt_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    assign out_o     = filt_q;
    assign posedge_o = filt_q & ~prev_q;
    assign negedge_o = ~filt_q & prev_q;
    assign glitch_o  = glitch_q;
endmodule

// File: rtl/spi_helpers_multi_sync_filter.sv
// N-channel SPI pad synchronizer with runtime deglitch filter and edge/glitch reporting.
module spi_helpers_multi_sync_filter
    import spi_helpers_multi_sync_filter_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILT_W      = 3,
    parameter logic [N_CH-1:0] RESET_VALUE = '0
) (
    input logic                           clk,
    input logic                           reset,
    spi_helpers_multi_sync_filter_if.slave bus
);
    logic [N_CH-1:0] out_w, pos_w, neg_w, glitch_w;

    if (SYNC_STAGES < SPI_MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $error("SYNC_STAGES=%0d is below the minimum of %0d", SYNC_STAGES, SPI_MIN_SYNC_STAGES);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        spi_helpers_multi_sync_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .RESET_VAL   (RESET_VALUE[i])
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .in_i         (bus.in_[i]),
            .filt_en_i    (bus.filt_en[i]),
            .filt_len_i   (bus.filt_len),
            .glitch_clr_i (bus.glitch_clr),
            .out_o        (out_w[i]),
            .posedge_o    (pos_w[i]),
            .negedge_o    (neg_w[i]),
            .glitch_o     (glitch_w[i])
        );
    end

    assign bus.out      = out_w;
    assign bus.posedge_ = pos_w;
    assign bus.negedge_ = neg_w;
    assign bus.glitch   = glitch_w;
    assign bus.any_edge = |(pos_w | neg_w);
endmodule

// File: tb/tb_spi_helpers_multi_sync_filter.sv
// Directed + randomized check of the SPI multi-channel sync filter against a streak-count model.
module tb_spi_helpers_multi_sync_filter;
    localparam int         N  = 4;
    localparam int         S  = 2;
    localparam int         W  = 3;
    localparam logic [3:0] RV = 4'b0100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_helpers_multi_sync_filter_if #(.N_CH(N), .FILT_W(W)) bus ();

    spi_helpers_multi_sync_filter #(
        .N_CH(N), .SYNC_STAGES(S), .FILT_W(W), .RESET_VALUE(RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: pad samples delayed S cycles, then a level is accepted once it
    // has been seen on L+1 consecutive samples; a streak that ends early is a glitch.
    logic [3:0] m_dly [S];
    logic [3:0] m_out, m_prev, m_glitch;
    int         m_streak [N];

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [3:0] raw, nxt, abort;
        int         len;
        if (reset) begin
            for (int s = 0; s < S; s++) m_dly[s] = RV;
            m_out = RV; m_prev = RV; m_glitch = '0;
            for (int i = 0; i < N; i++) m_streak[i] = 0;
            return;
        end
        raw   = m_dly[S-1];
        nxt   = m_out;
        abort = '0;
        len   = int'(bus.filt_len);
        for (int i = 0; i < N; i++) begin
            if (!bus.filt_en[i]) begin
                nxt[i] = raw[i];
                m_streak[i] = 0;
            end else if (raw[i] == m_out[i]) begin
                abort[i] = (m_streak[i] > 0);
                m_streak[i] = 0;
            end else begin
                m_streak[i] = m_streak[i] + 1;
                if (m_streak[i] >= len + 1) begin
                    nxt[i] = raw[i];
                    m_streak[i] = 0;
                end
            end
        end
        m_glitch = abort | (bus.glitch_clr ? 4'b0000 : m_glitch);
        m_prev   = m_out;
        m_out    = nxt;
        for (int s = S - 1; s > 0; s--) m_dly[s] = m_dly[s-1];
        m_dly[0] = bus.in_;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("out",      bus.out,      m_out);
        chk("posedge",  bus.posedge_, m_out & ~m_prev);
        chk("negedge",  bus.negedge_, ~m_out & m_prev);
        chk("any_edge", {3'b000, bus.any_edge}, {3'b000, |(m_out ^ m_prev)});
        chk("glitch",   bus.glitch,   m_glitch);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        reset = 1'b1;
        bus.in_ = RV; bus.filt_en = '0; bus.filt_len = '0; bus.glitch_clr = 1'b0;
        steps(2);
        reset = 1'b0;

        // reset level held, no edges, no glitch
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rst_out", bus.out, RV);
            chk("rst_edges", bus.posedge_ | bus.negedge_ | bus.glitch, 4'b0000);
        end

        // bypass latency: 3 edges
        bus.in_ = 4'b0101;
        steps(2);
        chk("byp_early", bus.out, RV);
        step();
        chk("byp_out", bus.out, 4'b0101);
        chk("byp_pos", bus.posedge_, 4'b0001);
        chk("byp_any", {3'b000, bus.any_edge}, 4'b0001);
        step();
        chk("byp_pos_end", bus.posedge_, 4'b0000);

        // filter L=3: 4-cycle pulse passes after 6 edges, 3-cycle pulse is a glitch
        bus.filt_en = 4'b0010; bus.filt_len = 3'd3;
        steps(4);
        bus.in_[1] = 1'b1; steps(4);
        bus.in_[1] = 1'b0; step();
        chk("filt_wait", bus.out, 4'b0101);
        step();
        chk("filt_rise", bus.out, 4'b0111);
        steps(8);
        chk("filt_fall", bus.out, 4'b0101);
        bus.in_[1] = 1'b1; steps(3);
        bus.in_[1] = 1'b0; steps(4);
        chk("short_out", bus.out, 4'b0101);
        chk("short_glitch", bus.glitch, 4'b0010);

        // abort coincident with clear keeps the flag; plain clear drops it
        bus.in_[1] = 1'b1; step();
        bus.in_[1] = 1'b0; steps(2);
        bus.glitch_clr = 1'b1; step(); bus.glitch_clr = 1'b0;
        chk("clr_vs_set", bus.glitch, 4'b0010);
        steps(2);
        bus.glitch_clr = 1'b1; step(); bus.glitch_clr = 1'b0;
        chk("clr_only", bus.glitch, 4'b0000);

        // lowering filt_len mid-count commits on the next edge
        bus.filt_en = 4'b1000; bus.filt_len = 3'd7;
        bus.in_[3] = 1'b1; steps(6);
        chk("len7_hold", bus.out, 4'b0101);
        bus.filt_len = 3'd1; step();
        chk("len_drop", bus.out, 4'b1101);
        chk("len_drop_neg", bus.negedge_, 4'b0000);

        // reset mid-count discards the pending fall without edge pulses
        bus.filt_len = 3'd7; bus.in_[3] = 1'b0; steps(5);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_mid_out", bus.out, RV);
        chk("rst_mid_edges", bus.posedge_ | bus.negedge_, 4'b0000);
        step();
        chk("rst_mid_edges2", bus.posedge_ | bus.negedge_, 4'b0000);

        // simultaneous rise on every channel
        bus.filt_en = '0; bus.in_ = 4'b0000; steps(6);
        bus.in_ = 4'b1111; steps(3);
        chk("all_pos", bus.posedge_, 4'b1111);
        chk("all_any", {3'b000, bus.any_edge}, 4'b0001);
        step();
        chk("all_any_end", {3'b000, bus.any_edge}, 4'b0000);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) bus.in_[i] = ~bus.in_[i];
            if ($urandom_range(40) == 0) bus.filt_en  = 4'($urandom);
            if ($urandom_range(30) == 0) bus.filt_len = 3'($urandom);
            bus.glitch_clr = ($urandom_range(15) == 0);
            reset          = ($urandom_range(400) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
